// File: rtl/alu_cmd_queue.sv
// Circular command FIFO ahead of the 4-bit ALU: valid/ready intake, one
// registered {opcode, a, b} issue per cycle when the ALU side is ready.
module alu_cmd_queue #(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_opcode,
  input  logic [3:0]       in_a,
  input  logic [3:0]       in_b,
  input  logic             out_ready,
  output logic             alu_valid,
  output logic [1:0]       alu_opcode,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef struct packed {
    logic [1:0] op;
    logic [3:0] a;
    logic [3:0] b;
  } cmd_t;

  cmd_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             push, pop;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign in_ready = !full;
  // flush/reset suppress both sides; no pass-through when full, no bypass when empty
  assign push     = in_valid && in_ready && !flush && !reset;
  assign pop      = out_ready && !empty && !flush && !reset;

  // Storage carries no reset; contents are don't-care once pointers clear.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{op: in_opcode, a: in_a, b: in_b};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      alu_valid  <= 1'b0;
      alu_opcode <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      alu_valid <= 1'b0;
    end else begin
      alu_valid <= pop;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) begin
        rd_ptr     <= rd_ptr + PTR_W'(1);
        alu_opcode <= mem[rd_ptr].op;
        alu_a      <= mem[rd_ptr].a;
        alu_b      <= mem[rd_ptr].b;
      end
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_alu_cmd_queue.sv
// Bench for alu_cmd_queue: directed + random steps against a queue-based model.
module tb_alu_cmd_queue;
  localparam int DEPTH = 8;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             reset, flush, in_valid, in_ready, out_ready;
  logic [1:0]       in_opcode, alu_opcode;
  logic [3:0]       in_a, in_b, alu_a, alu_b;
  logic             alu_valid, full, empty;
  logic [CNT_W-1:0] count;

  alu_cmd_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_a(in_a), .in_b(in_b),
    .out_ready(out_ready), .alu_valid(alu_valid),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int pulses = 0;
  int max_cnt = 0;

  // model: pending commands as {op,a,b} plus the ALU-side registers
  logic [9:0] q[$];
  logic       m_valid;
  logic [9:0] m_out;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic iv, input logic [1:0] op, input logic [3:0] a,
                      input logic [3:0] b, input logic ordy,
                      input logic fl = 1'b0, input logic rst = 1'b0);
    bit acc, pp;
    @(negedge clk);
    in_valid = iv; in_opcode = op; in_a = a; in_b = b;
    out_ready = ordy; flush = fl; reset = rst;
    if (rst) begin
      q.delete(); m_valid = 1'b0; m_out = '0;
    end else if (fl) begin
      q.delete(); m_valid = 1'b0;
    end else begin
      acc = iv && (q.size() < DEPTH);
      pp  = ordy && (q.size() > 0);
      m_valid = pp;
      if (pp) m_out = q.pop_front();
      if (acc) q.push_back({op, a, b});
    end
    @(posedge clk);
    #1;
    check("alu_valid", alu_valid, m_valid);
    check("alu_cmd", {alu_opcode, alu_a, alu_b}, m_out);
    check("count", count, q.size());
    check("full", full, q.size() == DEPTH);
    check("empty", empty, q.size() == 0);
    check("in_ready", in_ready, q.size() < DEPTH);
    if (alu_valid) pulses++;
    if (int'(count) > max_cnt) max_cnt = int'(count);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_opcode = '0; in_a = '0; in_b = '0;
    m_valid = 1'b0; m_out = '0;

    // reset held two cycles with a command offered
    step(1, 2'd1, 4'd5, 4'd6, 1, 0, 1);
    step(1, 2'd1, 4'd5, 4'd6, 1, 0, 1);

    // single Add 3,-2: exactly one pulse, two edges after the push
    pulses = 0;
    step(1, 2'd0, 4'd3, 4'hE, 1);
    check("lat_edge1", alu_valid, 1'b0);
    step(0, 2'd0, 4'd0, 4'd0, 1);
    check("lat_edge2_cmd", {alu_valid, alu_opcode, alu_a, alu_b}, {1'b1, 2'd0, 4'd3, 4'hE});
    step(0, 2'd0, 4'd0, 4'd0, 1);
    step(0, 2'd0, 4'd0, 4'd0, 1);
    check("single_pulses", pulses, 1);

    // fill to full, 9th rejected, then drain in order
    for (int i = 0; i < 8; i++) step(1, 2'd1, 4'(i), 4'(i - 4), 0);
    check("full_count", count, 8);
    step(1, 2'd1, 4'd9, 4'd9, 0);
    check("ninth_rejected", count, 8);
    pulses = 0;
    for (int i = 0; i < 9; i++) step(0, 2'd0, 4'd0, 4'd0, 1);
    check("drain_pulses", pulses, 8);

    // simultaneous push/pop at count 3
    for (int i = 0; i < 3; i++) step(1, 2'd0, 4'(i + 1), 4'(i + 1), 0);
    step(1, 2'd2, 4'h8, 4'd0, 1);
    check("pushpop_count", count, 3);
    check("pushpop_oldest", {alu_opcode, alu_a, alu_b}, {2'd0, 4'd1, 4'd1});
    step(0, 2'd0, 4'd0, 4'd0, 1);
    step(0, 2'd0, 4'd0, 4'd0, 1);
    step(0, 2'd0, 4'd0, 4'd0, 1);
    check("new_third_pop", {alu_valid, alu_opcode, alu_a, alu_b}, {1'b1, 2'd2, 4'h8, 4'd0});
    step(0, 2'd0, 4'd0, 4'd0, 1);

    // random stream with random back-pressure, wraps pointers several times
    max_cnt = 0;
    for (int i = 0; i < 80; i++)
      step(1'($urandom_range(0, 3) != 0), 2'($urandom), 4'($urandom), 4'($urandom),
           1'($urandom_range(0, 1)));
    for (int i = 0; i < 10; i++) step(0, 2'd0, 4'd0, 4'd0, 1);
    check("rand_max_cnt_le_depth", max_cnt <= DEPTH, 1'b1);
    check("rand_drained", empty, 1'b1);

    // flush with push and pop offered at count 5
    for (int i = 0; i < 5; i++) step(1, 2'd3, 4'(i), 4'(7 - i), 0);
    step(1, 2'd0, 4'd7, 4'd7, 1, 1, 0);
    check("flush_count", count, 0);
    check("flush_valid", alu_valid, 1'b0);
    step(0, 2'd0, 4'd0, 4'd0, 1);

    // same with reset, which also clears alu_*
    for (int i = 0; i < 5; i++) step(1, 2'd1, 4'(i + 2), 4'(i), 1'(i == 0));
    step(1, 2'd0, 4'd7, 4'd7, 1, 0, 1);
    check("reset_clears_alu", {alu_valid, alu_opcode, alu_a, alu_b, count}, '0);
    step(0, 2'd0, 4'd0, 4'd0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
